// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types for the integer divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bsg_vanilla_pkg;

   // RV32M divide/remainder flavours as tagged by decode.
   typedef enum logic [1:0] {
      eDIV  = 2'b00,
      eDIVU = 2'b01,
      eREM  = 2'b10,
      eREMU = 2'b11
   } idiv_op_e;

   // Sequencer states of the iterative divider.
   typedef enum logic [1:0] {
      eIDIV_IDLE = 2'b00,
      eIDIV_CALC = 2'b01,
      eIDIV_FIX  = 2'b10,
      eIDIV_DONE = 2'b11
   } idiv_state_e;

   // One restoring iteration per quotient bit.
   localparam int idiv_iter_gp = 32;

   // True for the signed flavours (DIV, REM).
   function automatic logic idiv_is_signed(input idiv_op_e op);
      return (op == eDIV) || (op == eREM);
   endfunction

   // True when the remainder, not the quotient, is the architectural result.
   function automatic logic idiv_is_rem(input idiv_op_e op);
      return (op == eREM) || (op == eREMU);
   endfunction

endpackage

// File: rtl/vanilla_idiv_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is used.
module vanilla_idiv_step #(
   parameter int width_p = 32
) (
   input  logic [width_p-1:0] rem_i,
   input  logic               dividend_msb_i,
   input  logic [width_p-1:0] divisor_i,
   output logic [width_p-1:0] rem_o,
   output logic               q_bit_o
);

   // The partial keeps the full remainder so divisors with the top bit set
   // (large unsigned values) still compare correctly.
   logic [width_p:0]   partial;
   logic [width_p+1:0] diff;
   logic               unused_diff_top;

   // Trial subtract; the borrow out of the wide subtract picks restore or keep.
   always_comb begin
      partial = {rem_i, dividend_msb_i};
      diff    = {1'b0, partial} - {2'b00, divisor_i};
      q_bit_o = ~diff[width_p+1];
      rem_o   = q_bit_o ? diff[width_p-1:0] : partial[width_p-1:0];
   end

   // When no borrow occurs the difference is below the divisor, so this bit is always 0.
   assign unused_diff_top = diff[width_p];

endmodule

// File: rtl/vanilla_idiv_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one operation in flight.
// Latency: accept edge at cycle 0, 32 CALC cycles, 1 FIX cycle, v_o from cycle 34.
// Backpressure: ready_o only in IDLE; result held in DONE until yumi_i.
module vanilla_idiv_seq
   import bsg_vanilla_pkg::*;
#(
   parameter int data_width_p     = 32,
   parameter int reg_addr_width_p = 5
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        v_i,
   output logic                        ready_o,
   input  idiv_op_e                    op_i,
   input  logic [data_width_p-1:0]     rs1_i,
   input  logic [data_width_p-1:0]     rs2_i,
   input  logic [reg_addr_width_p-1:0] rd_i,
   input  logic                        kill_i,
   output logic                        v_o,
   output logic [data_width_p-1:0]     result_o,
   output logic [reg_addr_width_p-1:0] rd_o,
   input  logic                        yumi_i
);

   localparam int cnt_width_lp = $clog2(idiv_iter_gp);

   idiv_state_e                 state_r, state_n;
   logic                        accept;

   idiv_op_e                    op_r;
   logic [reg_addr_width_p-1:0] rd_r;
   logic [reg_addr_width_p-1:0] rd_out_r;
   logic                        neg_a_r, neg_b_r;
   logic [data_width_p-1:0]     dividend_r;
   logic [data_width_p-1:0]     divisor_r;
   logic [data_width_p-1:0]     rem_r;
   logic [data_width_p-1:0]     quot_r;
   logic [data_width_p-1:0]     result_r;
   logic [cnt_width_lp-1:0]     cnt_r;

   logic                        in_signed;
   logic                        neg_a, neg_b;
   logic [data_width_p-1:0]     abs_a, abs_b;

   logic [data_width_p-1:0]     step_rem;
   logic                        step_q;

   logic                        op_signed_r;
   logic                        quot_neg, rem_neg;
   logic [data_width_p-1:0]     fix_result;

   // Operand sign capture and magnitude conversion at accept time.
   always_comb begin
      in_signed = idiv_is_signed(op_i);
      neg_a     = in_signed & rs1_i[data_width_p-1];
      neg_b     = in_signed & rs2_i[data_width_p-1];
      abs_a     = neg_a ? -rs1_i : rs1_i;
      abs_b     = neg_b ? -rs2_i : rs2_i;
   end

   vanilla_idiv_step #(
      .width_p(data_width_p)
   ) step (
      .rem_i         (rem_r),
      .dividend_msb_i(dividend_r[data_width_p-1]),
      .divisor_i     (divisor_r),
      .rem_o         (step_rem),
      .q_bit_o       (step_q)
   );

   // Sign fix-up; a zero divisor keeps the all-ones quotient unnegated.
   always_comb begin
      op_signed_r = idiv_is_signed(op_r);
      quot_neg    = op_signed_r & (neg_a_r ^ neg_b_r) & (divisor_r != '0);
      rem_neg     = op_signed_r & neg_a_r;
      if (idiv_is_rem(op_r)) begin
         fix_result = rem_neg ? -rem_r : rem_r;
      end else begin
         fix_result = quot_neg ? -quot_r : quot_r;
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= eIDIV_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state and handshake outputs; kill beats a same-cycle request in IDLE.
   always_comb begin
      state_n = state_r;
      ready_o = 1'b0;
      v_o     = 1'b0;
      accept  = 1'b0;
      unique case (state_r)
         eIDIV_IDLE: begin
            ready_o = 1'b1;
            accept  = v_i & ~kill_i;
            if (accept) begin
               state_n = eIDIV_CALC;
            end
         end
         eIDIV_CALC: begin
            if (kill_i) begin
               state_n = eIDIV_IDLE;
            end else if (cnt_r == '0) begin
               state_n = eIDIV_FIX;
            end
         end
         eIDIV_FIX: begin
            state_n = kill_i ? eIDIV_IDLE : eIDIV_DONE;
         end
         eIDIV_DONE: begin
            v_o = 1'b1;
            if (yumi_i) begin
               state_n = eIDIV_IDLE;
            end
         end
         default: state_n = eIDIV_IDLE;
      endcase
   end

   // Datapath: latch request, iterate in CALC, register the fixed-up result in FIX.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         op_r       <= eDIV;
         rd_r       <= '0;
         rd_out_r   <= '0;
         neg_a_r    <= 1'b0;
         neg_b_r    <= 1'b0;
         dividend_r <= '0;
         divisor_r  <= '0;
         rem_r      <= '0;
         quot_r     <= '0;
         result_r   <= '0;
         cnt_r      <= '0;
      end else if (accept) begin
         op_r       <= op_i;
         rd_r       <= rd_i;
         neg_a_r    <= neg_a;
         neg_b_r    <= neg_b;
         dividend_r <= abs_a;
         divisor_r  <= abs_b;
         rem_r      <= '0;
         quot_r     <= '0;
         cnt_r      <= cnt_width_lp'(idiv_iter_gp - 1);
      end else if (state_r == eIDIV_CALC) begin
         rem_r      <= step_rem;
         dividend_r <= {dividend_r[data_width_p-2:0], 1'b0};
         quot_r     <= {quot_r[data_width_p-2:0], step_q};
         if (cnt_r != '0) begin
            cnt_r <= cnt_r - cnt_width_lp'(1);
         end
      end else if ((state_r == eIDIV_FIX) && !kill_i) begin
         result_r <= fix_result;
         rd_out_r <= rd_r;
      end
   end

   assign result_o = result_r;
   assign rd_o     = rd_out_r;

   // The consumer may only take a result that is being offered.
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(yumi_i && !v_o));
      end
   end

endmodule

// File: tb/tb_vanilla_idiv_seq.sv
// Directed bench for the iterative divider with a queue-based scoreboard.
// Latency: checks v_o arrives in cycle 34 after the accept edge.
// Backpressure: monitor owns yumi_i and can hold results in DONE.
module tb_vanilla_idiv_seq;
   import bsg_vanilla_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        v_i;
   logic        ready_o;
   idiv_op_e    op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_i;
   logic        kill_i;
   logic        v_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        yumi_i;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
   } exp_t;

   exp_t exp_q[$];
   int   errors   = 0;
   int   checks   = 0;
   bit   hold_req = 1'b0;
   int   busy     = 0;

   vanilla_idiv_seq #(
      .data_width_p    (32),
      .reg_addr_width_p(5)
   ) dut (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (v_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .rd_i     (rd_i),
      .kill_i   (kill_i),
      .v_o      (v_o),
      .result_o (result_o),
      .rd_o     (rd_o),
      .yumi_i   (yumi_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected entry whenever a result is offered, then takes it.
   initial begin : monitor
      exp_t e;
      yumi_i = 1'b0;
      forever begin
         @(negedge clk_i);
         yumi_i = 1'b0;
         if (!reset_n_i) begin
            busy = 0;
         end else if (v_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_v_o: got result 0x%08h rd %0d, expected no result", result_o, rd_o);
               yumi_i = 1'b1;
            end else begin
               e = exp_q[0];
               check("latency_busy_cycles", 32'(busy), 32'd33);
               if (hold_req) begin
                  for (int i = 0; i < 10; i++) begin
                     @(negedge clk_i);
                     check("hold_v_o", 32'(v_o), 32'd1);
                     check("hold_result", result_o, e.result);
                     check("hold_rd", 32'(rd_o), 32'(e.rd));
                  end
                  hold_req = 1'b0;
               end
               void'(exp_q.pop_front());
               check("result", result_o, e.result);
               check("rd", 32'(rd_o), 32'(e.rd));
               yumi_i = 1'b1;
               @(negedge clk_i);
               yumi_i = 1'b0;
               check("post_yumi_v_o", 32'(v_o), 32'd0);
               check("post_yumi_ready", 32'(ready_o), 32'd1);
            end
            busy = 0;
         end else if (!ready_o) begin
            busy++;
         end else begin
            busy = 0;
         end
      end
   end

   task automatic wait_idle(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || !ready_o) && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL %s_timeout: got no completion in %0d cycles, expected idle", name, t);
         exp_q.delete();
      end
   endtask

   task automatic issue(input idiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk_i);
      v_i   = 1'b1;
      op_i  = op;
      rs1_i = a;
      rs2_i = b;
      rd_i  = rd;
      @(negedge clk_i);
      v_i   = 1'b0;
   endtask

   task automatic do_op(input string name, input idiv_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      exp_t e;
      e.result = exp;
      e.rd     = rd;
      exp_q.push_back(e);
      issue(op, a, b, rd);
      wait_idle(name);
   endtask

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      reset_n_i = 1'b0;
      v_i       = 1'b0;
      kill_i    = 1'b0;
      op_i      = eDIV;
      rs1_i     = '0;
      rs2_i     = '0;
      rd_i      = '0;
      repeat (3) @(negedge clk_i);
      check("reset_ready", 32'(ready_o), 32'd1);
      check("reset_v_o", 32'(v_o), 32'd0);
      check("reset_result", result_o, 32'h0);
      check("reset_rd", 32'(rd_o), 32'd0);
      reset_n_i = 1'b1;

      do_op("div_7_m2",    eDIV,  32'd7,          32'hFFFF_FFFE, 5'd1,  32'hFFFF_FFFD);
      do_op("rem_7_m2",    eREM,  32'd7,          32'hFFFF_FFFE, 5'd2,  32'h0000_0001);
      do_op("divu_max_2",  eDIVU, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'h7FFF_FFFF);
      do_op("remu_max_2",  eREMU, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'h0000_0001);
      do_op("div_5_0",     eDIV,  32'd5,          32'd0,         5'd5,  32'hFFFF_FFFF);
      do_op("div_m5_0",    eDIV,  32'hFFFF_FFFB,  32'd0,         5'd6,  32'hFFFF_FFFF);
      do_op("rem_m5_0",    eREM,  32'hFFFF_FFFB,  32'd0,         5'd7,  32'hFFFF_FFFB);
      do_op("divu_0_0",    eDIVU, 32'd0,          32'd0,         5'd8,  32'hFFFF_FFFF);
      do_op("div_ovf",     eDIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
      do_op("rem_ovf",     eREM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000);
      do_op("div_m100_7",  eDIV,  32'hFFFF_FF9C,  32'd7,         5'd12, 32'hFFFF_FFF2);
      do_op("rem_m100_7",  eREM,  32'hFFFF_FF9C,  32'd7,         5'd13, 32'hFFFF_FFFE);
      do_op("divu_big",    eDIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 5'd14, 32'h0000_0001);
      do_op("remu_big",    eREMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 5'd15, 32'h0000_0001);

      // Result held in DONE while the consumer stalls, then a fresh request.
      hold_req = 1'b1;
      do_op("hold_divu",   eDIVU, 32'd1000,       32'd10,        5'd9,  32'd100);
      do_op("after_hold",  eREMU, 32'd100,        32'd7,         5'd16, 32'd2);

      // Kill during CALC: back to IDLE, no result ever offered.
      issue(eDIV, 32'd12345, 32'd3, 5'd20);
      repeat (10) @(negedge clk_i);
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i = 1'b0;
      check("kill_calc_ready", 32'(ready_o), 32'd1);
      check("kill_calc_v_o", 32'(v_o), 32'd0);
      repeat (40) @(negedge clk_i);
      check("kill_calc_no_v_o", 32'(v_o), 32'd0);

      // Kill together with a request in IDLE: request is not accepted.
      @(negedge clk_i);
      v_i    = 1'b1;
      kill_i = 1'b1;
      op_i   = eDIVU;
      rs1_i  = 32'd50;
      rs2_i  = 32'd5;
      rd_i   = 5'd21;
      @(negedge clk_i);
      v_i    = 1'b0;
      kill_i = 1'b0;
      check("kill_idle_ready", 32'(ready_o), 32'd1);
      repeat (40) @(negedge clk_i);
      check("kill_idle_no_v_o", 32'(v_o), 32'd0);

      // Asynchronous reset in the middle of CALC.
      issue(eDIV, 32'd999, 32'd3, 5'd22);
      repeat (5) @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      check("midreset_ready", 32'(ready_o), 32'd1);
      check("midreset_v_o", 32'(v_o), 32'd0);
      check("midreset_result", result_o, 32'h0);
      check("midreset_rd", 32'(rd_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      do_op("div_100_7",   eDIV,  32'd100,        32'd7,         5'd17, 32'd14);

      wait_idle("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
